// File: rtl/lpdaq_frame_pkg.sv
// Shared framing definitions for the acquisition transport path: FSM states,
// header/trailer field layout and the sample sign-extension helper.
package lpdaq_frame_pkg;

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, TRAILER} frame_state_e;

    localparam logic [15:0] FRAME_MAGIC    = 16'hA55A;

    localparam int          HDR_MAGIC_LSB  = 16;
    localparam int          HDR_SEQ_LSB    = 0;
    localparam int          TRL_FORCED_BIT = 31;
    localparam int          TRL_COUNT_LSB  = 16;
    localparam int          TRL_CSUM_LSB   = 0;

    // v carries a dw-bit two's-complement value in its low bits.
    function automatic logic [31:0] sext32(input logic [31:0] v, input int dw);
        logic [31:0] sh;
        sh = v << (32 - dw);
        return 32'($signed(sh) >>> (32 - dw));
    endfunction

    function automatic logic [31:0] mk_header(input logic [15:0] magic, input logic [15:0] seq);
        logic [31:0] w;
        w = '0;
        w[HDR_MAGIC_LSB +: 16] = magic;
        w[HDR_SEQ_LSB +: 16]   = seq;
        return w;
    endfunction

    function automatic logic [31:0] mk_trailer(input logic forced, input logic [14:0] cnt,
                                               input logic [15:0] csum);
        logic [31:0] w;
        w = '0;
        w[TRL_FORCED_BIT]      = forced;
        w[TRL_COUNT_LSB +: 15] = cnt;
        w[TRL_CSUM_LSB +: 16]  = csum;
        return w;
    endfunction

endpackage

// File: rtl/str_frame_packer.sv
// Wraps tlast-delimited signed samples into header / payload / trailer frames
// behind a single AXI-Stream output register.
module str_frame_packer
    import lpdaq_frame_pkg::*;
#(
    parameter int          DW      = 24,
    parameter int          MAX_LEN = 16000,
    parameter logic [15:0] MAGIC   = FRAME_MAGIC
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] s_axis_tdata,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic          s_axis_tlast,
    output logic [31:0]   m_axis_tdata,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic          m_axis_tlast
);

    frame_state_e state_q, state_d;
    logic [15:0]  seq_q, seq_d;
    logic [14:0]  cnt_q, cnt_d;
    logic [15:0]  csum_q, csum_d;
    logic         forced_q, forced_d;
    logic [31:0]  tdata_q, tdata_d;
    logic         tvalid_q, tvalid_d;
    logic         tlast_q, tlast_d;

    logic         out_free;
    logic [31:0]  sample_x;
    logic [14:0]  cnt_inc;

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;

    always_comb begin
        out_free = !tvalid_q || m_axis_tready;
        sample_x = sext32(32'(s_axis_tdata), DW);
        cnt_inc  = cnt_q + 15'd1;

        state_d       = state_q;
        seq_d         = seq_q;
        cnt_d         = cnt_q;
        csum_d        = csum_q;
        forced_d      = forced_q;
        tdata_d       = tdata_q;
        tvalid_d      = tvalid_q && !m_axis_tready;
        tlast_d       = tlast_q;
        s_axis_tready = 1'b0;

        case (state_q)
            IDLE: begin
                // Peek at the pending sample to open a frame; it is consumed in PAYLOAD.
                if (s_axis_tvalid && out_free) begin
                    tdata_d  = mk_header(MAGIC, seq_q);
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    state_d  = HEADER;
                end
            end
            HEADER: begin
                if (tvalid_q && m_axis_tready) state_d = PAYLOAD;
            end
            PAYLOAD: begin
                s_axis_tready = out_free;
                if (s_axis_tvalid && out_free) begin
                    tdata_d  = sample_x;
                    tvalid_d = 1'b1;
                    cnt_d    = cnt_inc;
                    csum_d   = csum_q + sample_x[15:0];
                    if (s_axis_tlast) begin
                        forced_d = 1'b0;
                        state_d  = TRAILER;
                    end else if (cnt_inc == 15'(MAX_LEN)) begin
                        forced_d = 1'b1;
                        state_d  = TRAILER;
                    end
                end
            end
            TRAILER: begin
                // tlast_q distinguishes "trailer pending" from "trailer on the bus".
                if (!tlast_q) begin
                    if (out_free) begin
                        tdata_d  = mk_trailer(forced_q, cnt_q, csum_q);
                        tvalid_d = 1'b1;
                        tlast_d  = 1'b1;
                    end
                end else if (tvalid_q && m_axis_tready) begin
                    tlast_d  = 1'b0;
                    seq_d    = seq_q + 16'd1;
                    cnt_d    = '0;
                    csum_d   = '0;
                    forced_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            seq_q    <= '0;
            cnt_q    <= '0;
            csum_q   <= '0;
            forced_q <= 1'b0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            seq_q    <= seq_d;
            cnt_q    <= cnt_d;
            csum_q   <= csum_d;
            forced_q <= forced_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

endmodule
